mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  CPU-side initiator for the 512x32 synchronous RAM: accepts byte/half/word load-store requests
//  on a valid/ready port, drives the RAM's memRead/memWrite/address/dataIn, and returns
//  aligned/extended load data. Sub-word stores use read-modify-write, because the RAM has no
//  byte enables. Sits between the CPU datapath and the RAM.
// PARAMETERS
//  ADDR_W  9  RAM word-address width; byte address is ADDR_W+2 bits. Data width is fixed at 32.
// PORTS
//  clock         in   1         system clock, rising edge
//  reset         in   1         asynchronous, active-high
//  req_valid     in   1         request present
//  req_ready     out  1         unit idle, request accepted on edge when valid&ready
//  req_write     in   1         1=store, 0=load
//  req_size      in   2         00=byte 01=half 10=word 11=reserved
//  req_signed    in   1         loads: sign-extend (1) / zero-extend (0)
//  req_addr      in   ADDR_W+2  byte address, little-endian lanes
//  req_wdata     in   32        store data, right-justified
//  resp_valid    out  1         one-cycle completion pulse (loads and stores)
//  resp_rdata    out  32        extended load data; 0 for stores/errors
//  resp_err      out  1         misaligned or reserved size; qualified by resp_valid
//  mem_read      out  1         to RAM memRead
//  mem_write     out  1         to RAM memWrite
//  mem_address   out  ADDR_W    to RAM address = req_addr[ADDR_W+1:2]
//  mem_wdata     out  32        to RAM dataIn
//  mem_rdata     in   32        from RAM dataOut (valid the cycle after mem_read edge)
// BEHAVIOUR
//  - Reset (async): state IDLE; req_ready=1, all other outputs 0; latched request cleared.
//  - Accept edge E0: latch addr/size/signed/write/wdata. req_ready=1 only in IDLE; req_valid ignored elsewhere.
//  - FSM IDLE->{RD,WR,RESP}; RD->CAP; CAP->{RESP (load), WR (sub-word store)}; WR->RESP; RESP->IDLE.
//  - RD: mem_read=1 one cycle. CAP: sample mem_rdata; load -> extract lane, extend, latch;
//    store -> merge wdata lane into word, latch merged word.
//  - WR: mem_write=1 one cycle, mem_wdata = wdata (word) or merged word. RESP: resp_valid=1 one cycle.
//  - Latency from accept edge E0 to resp_valid high: load 3 cycles (RD,CAP,RESP), word store 2 (WR,RESP),
//    sub-word store 4 (RD,CAP,WR,RESP), error 1 (RESP). Back-to-back: next accept in cycle after RESP.
//  - mem_read and mem_write never high together; mem_address held constant RD..WR.
//  - Alignment: half needs addr[0]=0, word needs addr[1:0]=0, size 11 always errors.
//    Error -> no RAM access, resp_err=1, resp_rdata=0.
//  - Byte lane k = bits [8k+7:8k], k=addr[1:0]; half lane = addr[1] (bits [31:16] when 1).
//  - Address wrap: none needed; top word (mem_address=511) is a normal access.
//  - Reset mid-operation: outputs drop immediately; a store in WR with reset before its edge is not committed; RMW never leaves a partial merge.
//  - No resp backpressure; consumer must take resp_valid pulse.
// STRUCTURE
//  - Package mem_access_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state enum, lane helpers.
//  - Sub-module mem_lane_align (combinational): load extract+extend and store merge from
//    (size, offset, signed, word, wdata). FSM and registers stay in mem_access_unit.
//  - Bench RAM model: 1-cycle registered read, write on edge, as the system RAM.
// TESTING
//  1. Word store 0xDEADBEEF @0x010 then word load @0x010 -> mem_write one cycle addr 4;
//     load resp 3 cycles after accept, rdata=0xDEADBEEF, err=0.
//  2. Mem word 4 = 0x80FF7F01; byte loads @0x011 signed -> 0x0000007F, @0x013 signed ->
//     0xFFFFFF80, @0x013 unsigned -> 0x00000080; half @0x012 signed -> 0xFFFF80FF.
//  3. Word 4 = 0x11223344; byte store 0xAB @0x012 -> RD,CAP,WR sequence, mem_wdata=0x11AB3344,
//     resp 4 cycles after accept; half store 0xBEEF @0x010 -> 0x11ABBEEF.
//  4. Half load @0x011, word load @0x012, size=11 @0x000 -> resp_valid next cycle, err=1,
//     rdata=0, mem_read/mem_write never asserted.
//  5. Back-to-back: req_valid held with 3 queued loads -> req_ready low in RD/CAP/RESP,
//     each accepted cycle after prior RESP, responses in order; req_valid in busy states ignored.
//  6. Assert reset during WR of a byte store (before edge) -> outputs 0 at once, RAM word
//     unchanged, req_ready=1 after release, next load returns old value.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings, FSM state type and byte/half lane helpers for the memory access unit.
package mem_access_pkg;

    // Access size encodings on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Transaction FSM states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    // True when the request cannot be performed: misaligned half/word or reserved size
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = off[0];
            SZ_WORD: err = (off != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Byte lane k of a little-endian word
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    // Half lane: upper half when hi is set
    function automatic logic [15:0] half_lane(input logic [31:0] word, input logic hi);
        return hi ? word[31:16] : word[15:0];
    endfunction

    // Replace byte lane k of word with b
    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] k,
                                             input logic [7:0] b);
        logic [31:0] w;
        w = word;
        case (k)
            2'd0:    w[7:0]   = b;
            2'd1:    w[15:8]  = b;
            2'd2:    w[23:16] = b;
            default: w[31:24] = b;
        endcase
        return w;
    endfunction

    // Replace half lane of word with h
    function automatic logic [31:0] put_half(input logic [31:0] word, input logic hi,
                                             input logic [15:0] h);
        return hi ? {h, word[15:0]} : {word[31:16], h};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge into a RAM word.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_signed,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  b;
    logic [15:0] h;

    // Select the addressed lane, extend it for loads and merge it for stores
    always_comb begin
        b          = byte_lane(word, offset);
        h          = half_lane(word, offset[1]);
        load_data  = word;
        store_word = wdata;
        case (size)
            SZ_BYTE: begin
                load_data  = {{24{is_signed & b[7]}}, b};
                store_word = put_byte(word, offset, wdata[7:0]);
            end
            SZ_HALF: begin
                load_data  = {{16{is_signed & h[15]}}, h};
                store_word = put_half(word, offset[1], wdata[15:0]);
            end
            default: begin
                load_data  = word;
                store_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side load/store initiator for a 32-bit synchronous RAM without byte enables.
// Sub-word stores use read-modify-write; the merged word is only written in WR,
// so a reset anywhere earlier leaves the RAM untouched.
//
// Request handshake: a request is taken on the rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE. There is no response
// backpressure: resp_valid is a single-cycle pulse the consumer must take.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [2:0]        dbg_state
);

    state_t            state, state_nx;
    logic              accept;
    logic [ADDR_W+1:0] addr_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic              write_q;
    logic              err_q;
    logic [31:0]       wdata_q;
    logic [31:0]       data_q;
    logic [31:0]       load_data;
    logic [31:0]       store_word;

    assign accept      = req_valid && (state == ST_IDLE);
    assign mem_address = addr_q[ADDR_W+1:2];
    assign dbg_state   = state;

    mem_lane_align u_align (
        .size       (size_q),
        .offset     (addr_q[1:0]),
        .is_signed  (signed_q),
        .word       (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and per-state outputs; all outputs derive from the current state
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_wdata  = 32'd0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (access_err(req_size, req_addr[1:0])) begin
                        state_nx = ST_RESP;
                    end else if (req_write && (req_size == SZ_WORD)) begin
                        state_nx = ST_WR;
                    end else begin
                        state_nx = ST_RD;
                    end
                end
            end
            ST_RD: begin
                mem_read = 1'b1;
                state_nx = ST_CAP;
            end
            ST_CAP: begin
                state_nx = write_q ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                mem_write = 1'b1;
                mem_wdata = (size_q == SZ_WORD) ? wdata_q : data_q;
                state_nx  = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (write_q || err_q) ? 32'd0 : data_q;
                state_nx   = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Request latch on accept; captured load data or merged store word in CAP
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= 32'd0;
            data_q   <= 32'd0;
        end else if (accept) begin
            addr_q   <= req_addr;
            size_q   <= req_size;
            signed_q <= req_signed;
            write_q  <= req_write;
            err_q    <= access_err(req_size, req_addr[1:0]);
            wdata_q  <= req_wdata;
            data_q   <= 32'd0;
        end else if (state == ST_CAP) begin
            data_q <= write_q ? store_word : load_data;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 1-cycle registered-read RAM model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [10:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [8:0]  mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [2:0]  dbg_state;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    mem_access_unit #(.ADDR_W(9)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .dbg_state   (dbg_state)
    );

    // ---------------- RAM model (plus bench backdoor write) ----------------
    logic [31:0] ram [0:511];
    logic        bd_we;
    logic [8:0]  bd_addr;
    logic [31:0] bd_data;

    always @(posedge clock) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (mem_write) ram[mem_address] <= mem_wdata;
        if (mem_read) mem_rdata <= ram[mem_address];
    end

    // ---------------- scoreboard / check ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rvalid"}, 32'(resp_valid), 32'd0);
        check({tag, "_rdata"}, resp_rdata, 32'd0);
        check({tag, "_err"}, 32'(resp_err), 32'd0);
        check({tag, "_mrd"}, 32'(mem_read), 32'd0);
        check({tag, "_mwr"}, 32'(mem_write), 32'd0);
        check({tag, "_maddr"}, 32'(mem_address), 32'd0);
        check({tag, "_mwdata"}, mem_wdata, 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // ---------------- driver ----------------
    int          lat, rd_at, wr_at, n_rd, n_wr;
    logic        both_hi, got_resp, r_err;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data, r_data;

    task automatic ram_poke(input logic [8:0] a, input logic [31:0] d);
        @(negedge clock);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clock);
        bd_we = 1'b0;
    endtask

    // Issue one request and observe the transaction up to its response (bounded)
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [10:0] a, input logic [31:0] wd);
        @(negedge clock);
        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(negedge clock);
        req_valid = 1'b0;
        lat = 0; rd_at = 0; wr_at = 0; n_rd = 0; n_wr = 0;
        both_hi = 1'b0; got_resp = 1'b0; r_err = 1'b0;
        wr_addr = '0; wr_data = '0; r_data = '0;
        for (int c = 1; c <= 12 && !got_resp; c++) begin
            if (mem_read) begin n_rd++; rd_at = c; end
            if (mem_write) begin
                n_wr++; wr_at = c; wr_addr = mem_address; wr_data = mem_wdata;
            end
            if (mem_read && mem_write) both_hi = 1'b1;
            if (resp_valid) begin
                got_resp = 1'b1; lat = c; r_data = resp_rdata; r_err = resp_err;
            end else begin
                @(negedge clock);
            end
        end
        check("resp_seen", 32'(got_resp), 32'd1);
        check("rd_wr_excl", 32'(both_hi), 32'd0);
    endtask

    logic [10:0] b2b_addr [3];
    int          acc_cyc [3];
    int          idx, nresp;
    logic        acc_now;

    initial begin
        #100000;
        $display("FAIL watchdog time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;

        // 1. word store then word load
        issue(1'b1, SZ_WORD, 1'b0, 11'h010, 32'hDEADBEEF);
        check("t1_st_lat", 32'(lat), 32'd2);
        check("t1_st_nwr", 32'(n_wr), 32'd1);
        check("t1_st_nrd", 32'(n_rd), 32'd0);
        check("t1_st_addr", 32'(wr_addr), 32'd4);
        check("t1_st_wdata", wr_data, 32'hDEADBEEF);
        check("t1_st_rdata", r_data, 32'd0);
        check("t1_st_err", 32'(r_err), 32'd0);
        issue(1'b0, SZ_WORD, 1'b0, 11'h010, 32'd0);
        check("t1_ld_lat", 32'(lat), 32'd3);
        check("t1_ld_nrd", 32'(n_rd), 32'd1);
        check("t1_ld_data", r_data, 32'hDEADBEEF);
        check("t1_ld_err", 32'(r_err), 32'd0);

        // 2. sub-word loads with extension
        ram_poke(9'd4, 32'h80FF7F01);
        issue(1'b0, SZ_BYTE, 1'b1, 11'h011, 32'd0);
        check("t2_b1_s", r_data, 32'h0000007F);
        issue(1'b0, SZ_BYTE, 1'b1, 11'h013, 32'd0);
        check("t2_b3_s", r_data, 32'hFFFFFF80);
        issue(1'b0, SZ_BYTE, 1'b0, 11'h013, 32'd0);
        check("t2_b3_u", r_data, 32'h00000080);
        issue(1'b0, SZ_HALF, 1'b1, 11'h012, 32'd0);
        check("t2_h2_s", r_data, 32'hFFFF80FF);
        issue(1'b0, SZ_BYTE, 1'b0, 11'h010, 32'd0);
        check("t2_b0_u", r_data, 32'h00000001);
        issue(1'b0, SZ_HALF, 1'b0, 11'h010, 32'd0);
        check("t2_h0_u", r_data, 32'h00007F01);

        // 3. read-modify-write stores
        ram_poke(9'd4, 32'h11223344);
        issue(1'b1, SZ_BYTE, 1'b0, 11'h012, 32'h000000AB);
        check("t3_b_rd_at", 32'(rd_at), 32'd1);
        check("t3_b_wr_at", 32'(wr_at), 32'd3);
        check("t3_b_lat", 32'(lat), 32'd4);
        check("t3_b_wdata", wr_data, 32'h11AB3344);
        check("t3_b_addr", 32'(wr_addr), 32'd4);
        check("t3_b_rdata", r_data, 32'd0);
        issue(1'b1, SZ_HALF, 1'b0, 11'h010, 32'h0000BEEF);
        check("t3_h_wdata", wr_data, 32'h11ABBEEF);
        check("t3_h_lat", 32'(lat), 32'd4);
        issue(1'b0, SZ_WORD, 1'b0, 11'h010, 32'd0);
        check("t3_readback", r_data, 32'h11ABBEEF);

        // 4. error cases
        issue(1'b0, SZ_HALF, 1'b1, 11'h011, 32'd0);
        check("t4_h_lat", 32'(lat), 32'd1);
        check("t4_h_err", 32'(r_err), 32'd1);
        check("t4_h_rdata", r_data, 32'd0);
        check("t4_h_mem", 32'(n_rd + n_wr), 32'd0);
        issue(1'b0, SZ_WORD, 1'b0, 11'h012, 32'd0);
        check("t4_w_lat", 32'(lat), 32'd1);
        check("t4_w_err", 32'(r_err), 32'd1);
        check("t4_w_mem", 32'(n_rd + n_wr), 32'd0);
        issue(1'b1, SZ_RSVD, 1'b0, 11'h000, 32'h12345678);
        check("t4_r_lat", 32'(lat), 32'd1);
        check("t4_r_err", 32'(r_err), 32'd1);
        check("t4_r_rdata", r_data, 32'd0);
        check("t4_r_mem", 32'(n_rd + n_wr), 32'd0);

        // top word is a normal access
        issue(1'b1, SZ_WORD, 1'b0, 11'h7FC, 32'h12345678);
        check("top_addr", 32'(wr_addr), 32'd511);
        issue(1'b0, SZ_WORD, 1'b0, 11'h7FC, 32'd0);
        check("top_data", r_data, 32'h12345678);
        check("top_err", 32'(r_err), 32'd0);

        // 5. back-to-back loads with req_valid held
        ram_poke(9'd20, 32'h0A0A0A01);
        ram_poke(9'd21, 32'h0B0B0B02);
        ram_poke(9'd22, 32'h0C0C0C03);
        b2b_addr[0] = 11'h050; b2b_addr[1] = 11'h054; b2b_addr[2] = 11'h058;
        exp_q.delete();
        exp_q.push_back(32'h0A0A0A01);
        exp_q.push_back(32'h0B0B0B02);
        exp_q.push_back(32'h0C0C0C03);
        acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
        idx = 0; nresp = 0;
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_size = SZ_WORD; req_signed = 1'b0;
        req_addr = b2b_addr[0];
        for (int cyc = 0; cyc < 40 && nresp < 3; cyc++) begin
            acc_now = 1'b0;
            if (resp_valid) begin
                if (exp_q.size() > 0) check("b2b_data", resp_rdata, exp_q.pop_front());
                check("b2b_lat", 32'(cyc - acc_cyc[nresp]), 32'd3);
                nresp++;
            end
            if (req_valid && req_ready && idx < 3) begin
                acc_cyc[idx] = cyc; idx++; acc_now = 1'b1;
            end
            @(negedge clock);
            if (acc_now) begin
                if (idx < 3) req_addr = b2b_addr[idx];
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        check("b2b_nresp", 32'(nresp), 32'd3);
        check("b2b_nacc", 32'(idx), 32'd3);
        check("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
        check("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);

        // 6. reset during WR of a byte store
        ram_poke(9'd8, 32'hCAFEF00D);
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
        req_addr = 11'h021; req_wdata = 32'h00000055;
        @(negedge clock);
        req_valid = 1'b0;
        check("t6_rd", 32'(mem_read), 32'd1);
        @(negedge clock);
        @(negedge clock);
        check("t6_wr", 32'(mem_write), 32'd1);
        check("t6_wdata", mem_wdata, 32'hCAFE550D);
        reset = 1'b1;
        #1;
        check_reset_outputs("t6_rst");
        @(negedge clock);
        reset = 1'b0;
        check("t6_ram", ram[8], 32'hCAFEF00D);
        #1;
        check("t6_ready", 32'(req_ready), 32'd1);
        issue(1'b0, SZ_WORD, 1'b0, 11'h020, 32'd0);
        check("t6_reload", r_data, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
